default_slave: RTL and testbench

DEFAULT_SLAVE -- requirements
Module: default_slave

---
 rtl/default_slave.sv | 160 ++++++++++++++++
 tb/tb_default_slave.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/default_slave.sv
// Unmapped-address responder for the AXI interconnect: accepts every read and write
// routed to it and answers with DECERR, using independent read and write FSMs.
module default_slave #(
  parameter int ID_BITS   = 8,
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  // read address
  input  logic [ID_BITS-1:0]     ARID,
  input  logic [ADDR_BITS-1:0]   ARADDR,
  input  logic [3:0]             ARLEN,
  input  logic [2:0]             ARSIZE,
  input  logic [1:0]             ARBURST,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  // read data
  output logic [ID_BITS-1:0]     RID,
  output logic [DATA_BITS-1:0]   RDATA,
  output logic [1:0]             RRESP,
  output logic                   RLAST,
  output logic                   RVALID,
  input  logic                   RREADY,
  // write address
  input  logic [ID_BITS-1:0]     AWID,
  input  logic [ADDR_BITS-1:0]   AWADDR,
  input  logic [3:0]             AWLEN,
  input  logic [2:0]             AWSIZE,
  input  logic [1:0]             AWBURST,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  // write data
  input  logic [DATA_BITS-1:0]   WDATA,
  input  logic [DATA_BITS/8-1:0] WSTRB,
  input  logic                   WLAST,
  input  logic                   WVALID,
  output logic                   WREADY,
  // write response
  output logic [ID_BITS-1:0]     BID,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY
);

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  r_state_e           r_state_q, r_state_d;
  w_state_e           w_state_q, w_state_d;
  logic [ID_BITS-1:0] rid_q, rid_d;
  logic [3:0]         rlen_q, rlen_d;
  logic [3:0]         beat_q, beat_d;
  logic [ID_BITS-1:0] bid_q, bid_d;

  // Address, size, burst type and write payload play no part in a DECERR reply.
  logic unused_inputs;
  assign unused_inputs = ^{ARADDR, ARSIZE, ARBURST, AWADDR, AWLEN, AWSIZE, AWBURST,
                           WDATA, WSTRB};

  // ---------------- read path ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      rlen_q    <= '0;
      beat_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      beat_q    <= beat_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rlen_d    = rlen_q;
    beat_d    = beat_q;
    case (r_state_q)
      R_IDLE: begin
        if (ARVALID && ARREADY) begin
          r_state_d = R_DATA;
          rid_d     = ARID;
          rlen_d    = ARLEN;
          beat_d    = '0;
        end
      end
      R_DATA: begin
        if (RVALID && RREADY) begin
          // The wrap to 0 after beat 15 is harmless: the last beat always leaves R_DATA.
          beat_d = beat_q + 4'd1;
          if (RLAST) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = (r_state_q == R_IDLE);
    RVALID  = (r_state_q == R_DATA);
    RLAST   = (r_state_q == R_DATA) && (beat_q == rlen_q);
    RRESP   = (r_state_q == R_DATA) ? RESP_DECERR : 2'b00;
    RID     = rid_q;
    RDATA   = '0;
  end

  // ---------------- write path ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      bid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    case (w_state_q)
      W_IDLE: begin
        if (AWVALID && AWREADY) begin
          w_state_d = W_DATA;
          bid_d     = AWID;
        end
      end
      W_DATA: begin
        // Beat count is deliberately not checked against AWLEN; only WLAST closes the burst.
        if (WVALID && WREADY && WLAST) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = (w_state_q == W_IDLE);
    WREADY  = (w_state_q == W_DATA);
    BVALID  = (w_state_q == W_RESP);
    BRESP   = (w_state_q == W_RESP) ? RESP_DECERR : 2'b00;
    BID     = bid_q;
  end

endmodule

// File: tb/tb_default_slave.sv
// Directed bench for default_slave: expected R beats and B responses are queued when
// requests are driven and checked by a monitor as each handshake occurs.
module tb_default_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  default_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [7:0] id;
    logic       last;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] b_q[$];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rd(input logic [7:0] id, input int len);
    for (int i = 0; i <= len; i++) begin
      rd_exp_t e;
      e.id   = id;
      e.last = (i == len);
      rd_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Scoreboard: pops one expectation per handshake seen at the falling edge.
  always @(negedge ACLK) begin
    if (ARESET !== 1'b1) begin
      if (RVALID && RREADY) begin
        chk("r_unexpected_beat", {31'd0, rd_q.size() == 0}, 32'd0);
        if (rd_q.size() != 0) begin
          rd_exp_t e;
          e = rd_q.pop_front();
          chk("r_id", {24'd0, RID}, {24'd0, e.id});
          chk("r_last", {31'd0, RLAST}, {31'd0, e.last});
          chk("r_data", RDATA, 32'd0);
          chk("r_resp", {30'd0, RRESP}, 32'd3);
        end
      end
      if (BVALID && BREADY) begin
        chk("b_unexpected", {31'd0, b_q.size() == 0}, 32'd0);
        if (b_q.size() != 0) begin
          logic [7:0] id;
          id = b_q.pop_front();
          chk("b_id", {24'd0, BID}, {24'd0, id});
          chk("b_resp", {30'd0, BRESP}, 32'd3);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ARESET = 1; ARID = 0; ARADDR = 32'h1234_0000; ARLEN = 0; ARSIZE = 3'd2; ARBURST = 2'd1;
    ARVALID = 0; RREADY = 0; AWID = 0; AWADDR = 32'h5678_0000; AWLEN = 4'd3; AWSIZE = 3'd2;
    AWBURST = 2'd1; AWVALID = 0; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WLAST = 0; WVALID = 0;
    BREADY = 0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_arready", {31'd0, ARREADY}, 32'd1);
    chk("rst_awready", {31'd0, AWREADY}, 32'd1);
    chk("rst_rvalid", {31'd0, RVALID}, 32'd0);
    chk("rst_rlast", {31'd0, RLAST}, 32'd0);
    chk("rst_wready", {31'd0, WREADY}, 32'd0);
    chk("rst_bvalid", {31'd0, BVALID}, 32'd0);
    chk("rst_rid", {24'd0, RID}, 32'd0);
    chk("rst_bid", {24'd0, BID}, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_rresp", {30'd0, RRESP}, 32'd0);
    chk("rst_bresp", {30'd0, BRESP}, 32'd0);
    step();
    ARESET = 0;

    // 4-beat read, RREADY high
    ARID = 8'h15; ARLEN = 4'd3; ARVALID = 1; RREADY = 1;
    push_rd(8'h15, 3);
    @(negedge ACLK);
    chk("t1_arready", {31'd0, ARREADY}, 32'd1);
    step();
    ARVALID = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("t1_rvalid", {31'd0, RVALID}, 32'd1);
      chk("t1_arready_busy", {31'd0, ARREADY}, 32'd0);
    end
    @(negedge ACLK);
    chk("t1_rvalid_end", {31'd0, RVALID}, 32'd0);
    chk("t1_drained", rd_q.size(), 32'd0);

    // single beat held by back-pressure for 5 cycles
    step();
    ARID = 8'h3C; ARLEN = 4'd0; ARVALID = 1; RREADY = 0;
    push_rd(8'h3C, 0);
    step();
    ARVALID = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("t2_rvalid", {31'd0, RVALID}, 32'd1);
      chk("t2_rlast", {31'd0, RLAST}, 32'd1);
      chk("t2_rid", {24'd0, RID}, 32'h3C);
      chk("t2_rresp", {30'd0, RRESP}, 32'd3);
    end
    step();
    RREADY = 1;
    step();
    @(negedge ACLK);
    chk("t2_rvalid_end", {31'd0, RVALID}, 32'd0);
    chk("t2_drained", rd_q.size(), 32'd0);

    // W data before AW is ignored
    step();
    WVALID = 1; WLAST = 1;
    @(negedge ACLK);
    chk("t3_wready_idle", {31'd0, WREADY}, 32'd0);
    step();
    WVALID = 0; WLAST = 0;
    @(negedge ACLK);
    chk("t3_bvalid_idle", {31'd0, BVALID}, 32'd0);
    chk("t3_awready_idle", {31'd0, AWREADY}, 32'd1);

    // 3-beat write
    step();
    AWID = 8'h2A; AWVALID = 1; BREADY = 1;
    b_q.push_back(8'h2A);
    step();
    AWVALID = 0; WVALID = 1;
    for (int b = 0; b < 3; b++) begin
      WLAST = (b == 2);
      @(negedge ACLK);
      chk("t3_wready", {31'd0, WREADY}, 32'd1);
      chk("t3_bvalid_early", {31'd0, BVALID}, 32'd0);
      step();
    end
    WVALID = 0; WLAST = 0;
    @(negedge ACLK);
    chk("t3_bvalid", {31'd0, BVALID}, 32'd1);
    step();
    @(negedge ACLK);
    chk("t3_bvalid_end", {31'd0, BVALID}, 32'd0);
    chk("t3_awready_end", {31'd0, AWREADY}, 32'd1);
    chk("t3_drained", b_q.size(), 32'd0);

    // WLAST on first beat, BREADY stalled
    step();
    AWID = 8'h61; AWVALID = 1; BREADY = 0;
    b_q.push_back(8'h61);
    step();
    AWVALID = 0; WVALID = 1; WLAST = 1;
    step();
    WVALID = 0; WLAST = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      chk("t4_bvalid_hold", {31'd0, BVALID}, 32'd1);
      chk("t4_bid_hold", {24'd0, BID}, 32'h61);
      chk("t4_wready_resp", {31'd0, WREADY}, 32'd0);
    end
    step();
    BREADY = 1;
    step();
    @(negedge ACLK);
    chk("t4_bvalid_end", {31'd0, BVALID}, 32'd0);
    chk("t4_drained", b_q.size(), 32'd0);

    // concurrent 16-beat read and 2-beat write
    step();
    ARID = 8'h71; ARLEN = 4'd15; ARVALID = 1; RREADY = 1;
    AWID = 8'h8E; AWVALID = 1; BREADY = 1;
    push_rd(8'h71, 15);
    b_q.push_back(8'h8E);
    step();
    ARVALID = 0; AWVALID = 0; WVALID = 1; WLAST = 0;
    step();
    WLAST = 1;
    step();
    WVALID = 0; WLAST = 0;
    n = 0;
    while ((rd_q.size() != 0 || b_q.size() != 0) && n < 40) begin
      @(posedge ACLK);
      n++;
    end
    chk("t5_timeout", {31'd0, n >= 40}, 32'd0);
    @(negedge ACLK);
    chk("t5_rvalid_end", {31'd0, RVALID}, 32'd0);
    chk("t5_bvalid_end", {31'd0, BVALID}, 32'd0);

    // reset on the 2nd of 4 beats
    step();
    ARID = 8'h42; ARLEN = 4'd3; ARVALID = 1; RREADY = 1;
    push_rd(8'h42, 3);
    step();
    ARVALID = 0;
    step();
    ARESET = 1;
    step();
    ARESET = 0;
    rd_q.delete();
    @(negedge ACLK);
    chk("t6_rvalid", {31'd0, RVALID}, 32'd0);
    chk("t6_arready", {31'd0, ARREADY}, 32'd1);
    chk("t6_rid", {24'd0, RID}, 32'd0);
    step();
    ARID = 8'h43; ARLEN = 4'd1; ARVALID = 1;
    push_rd(8'h43, 1);
    step();
    ARVALID = 0;
    repeat (2) @(negedge ACLK);
    @(negedge ACLK);
    chk("t6_rvalid_end", {31'd0, RVALID}, 32'd0);
    chk("t6_drained", rd_q.size(), 32'd0);

    // ARVALID held across burst end
    step();
    ARID = 8'h55; ARLEN = 4'd1; ARVALID = 1; RREADY = 1;
    push_rd(8'h55, 1);
    step();
    ARID = 8'h56; ARLEN = 4'd0;
    push_rd(8'h56, 0);
    @(negedge ACLK);
    chk("t7_arready_b0", {31'd0, ARREADY}, 32'd0);
    step();
    @(negedge ACLK);
    chk("t7_arready_b1", {31'd0, ARREADY}, 32'd0);
    chk("t7_rlast_b1", {31'd0, RLAST}, 32'd1);
    step();
    @(negedge ACLK);
    chk("t7_arready_idle", {31'd0, ARREADY}, 32'd1);
    chk("t7_rvalid_idle", {31'd0, RVALID}, 32'd0);
    step();
    ARVALID = 0;
    @(negedge ACLK);
    chk("t7_rvalid_second", {31'd0, RVALID}, 32'd1);
    step();
    @(negedge ACLK);
    chk("t7_rvalid_end", {31'd0, RVALID}, 32'd0);
    chk("t7_drained", rd_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
